// File: rtl/uart_sender.sv
// uart_sender: 8N1 UART transmitter with a one-byte holding register.
//
// Purpose
//   Takes a byte from the peripheral bus on a one-cycle TX_EN strobe and
//   sends it LSB-first on UART_TX: start bit (0), 8 data bits, stop bit (1).
//   The holding register lets the writer queue the next byte while the
//   current frame is still on the line. Queued frames follow back-to-back
//   with no idle bit in between.
//
// Parameters
//   CLK_FREQ  sysclk frequency in Hz
//   BAUD      line rate in bit/s
//             CLKS_PER_BIT = CLK_FREQ/BAUD is the bit length in sysclk
//             cycles and must be >= 2.
//
// Ports
//   sysclk     in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   TX_DATA    in   [7:0] byte to send, sampled only on an accepted TX_EN
//   TX_EN      in   write strobe, one cycle per byte
//   TX_STATUS  out  1 = holding register empty, a write will be accepted
//   TX_IDLE    out  1 = no frame in progress and holding register empty
//   UART_TX    out  serial line, idles high, registered
//
// Optional feature
//   UART_SENDER_PARITY_EN: when defined, an even-parity bit is sent between
//   the last data bit and the stop bit, giving an 11-bit frame.

module uart_sender #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic [7:0] TX_DATA,
    input  logic       TX_EN,
    output logic       TX_STATUS,
    output logic       TX_IDLE,
    output logic       UART_TX
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int BCW          = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BCW-1:0] LAST_CNT = BCW'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 2) begin : g_badRate
        $error("uart_sender: CLK_FREQ/BAUD must be at least 2");
    end

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_SENDER_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t           r_state;
    logic [BCW-1:0]   r_baudCnt;
    logic [2:0]       r_bitCnt;
    logic [7:0]       r_shift;
    logic [7:0]       r_hold;
    logic             r_holdValid;
    logic             r_tx;
    logic             r_idle;

    state_t           w_nextState;
    logic [BCW-1:0]   w_nextBaudCnt;
    logic [2:0]       w_nextBitCnt;
    logic [7:0]       w_nextShift;
    logic [7:0]       w_nextHold;
    logic             w_nextHoldValid;
    logic             w_nextTx;
    logic             w_terminal;
    logic             w_accept;
    logic             w_load;

`ifdef UART_SENDER_PARITY_EN
    logic             r_parity;
    logic             w_nextParity;
`endif

    // A write is only taken while the holding register is empty. The
    // hold->shift transfer needs hold full, so the two never coincide and a
    // strobe on the transfer edge is dropped.
    assign w_accept   = TX_EN && !r_holdValid;
    assign w_terminal = (r_baudCnt == LAST_CNT);

    // Next-state and datapath decode. Every line bit is CLKS_PER_BIT cycles;
    // bit and state advances happen only on the baud counter terminal count.
    always_comb begin
        w_nextState     = r_state;
        w_nextBaudCnt   = r_baudCnt;
        w_nextBitCnt    = r_bitCnt;
        w_nextShift     = r_shift;
        w_nextHold      = r_hold;
        w_nextHoldValid = r_holdValid;
        w_nextTx        = r_tx;
        w_load          = 1'b0;
`ifdef UART_SENDER_PARITY_EN
        w_nextParity    = r_parity;
`endif

        if (r_state == IDLE) begin
            w_load = r_holdValid;
        end else if (!w_terminal) begin
            w_nextBaudCnt = r_baudCnt + 1'b1;
        end else begin
            w_nextBaudCnt = '0;
            case (r_state)
                START: begin
                    w_nextState  = DATA;
                    w_nextBitCnt = 3'd0;
                    w_nextTx     = r_shift[0];
                end
                DATA: begin
                    if (r_bitCnt == 3'd7) begin
`ifdef UART_SENDER_PARITY_EN
                        w_nextState = PARITY;
                        w_nextTx    = r_parity;
`else
                        w_nextState = STOP;
                        w_nextTx    = 1'b1;
`endif
                    end else begin
                        w_nextBitCnt = r_bitCnt + 3'd1;
                        w_nextShift  = r_shift >> 1;
                        w_nextTx     = r_shift[1];
                    end
                end
`ifdef UART_SENDER_PARITY_EN
                PARITY: begin
                    w_nextState = STOP;
                    w_nextTx    = 1'b1;
                end
`endif
                STOP: begin
                    // A queued byte starts immediately, without an idle bit.
                    if (r_holdValid) begin
                        w_load = 1'b1;
                    end else begin
                        w_nextState = IDLE;
                        w_nextTx    = 1'b1;
                    end
                end
                default: begin
                    w_nextState = IDLE;
                    w_nextTx    = 1'b1;
                end
            endcase
        end

        if (w_load) begin
            w_nextState     = START;
            w_nextShift     = r_hold;
            w_nextHoldValid = 1'b0;
            w_nextTx        = 1'b0;
            w_nextBaudCnt   = '0;
`ifdef UART_SENDER_PARITY_EN
            w_nextParity    = ^r_hold;
`endif
        end

        if (w_accept) begin
            w_nextHold      = TX_DATA;
            w_nextHoldValid = 1'b1;
        end
    end

    // State register. TX_IDLE is registered from the next-state values so it
    // drops on the accepting edge and rises on the edge that ends the frame.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_baudCnt   <= '0;
            r_bitCnt    <= 3'd0;
            r_shift     <= 8'd0;
            r_hold      <= 8'd0;
            r_holdValid <= 1'b0;
            r_tx        <= 1'b1;
            r_idle      <= 1'b1;
        end else begin
            r_state     <= w_nextState;
            r_baudCnt   <= w_nextBaudCnt;
            r_bitCnt    <= w_nextBitCnt;
            r_shift     <= w_nextShift;
            r_hold      <= w_nextHold;
            r_holdValid <= w_nextHoldValid;
            r_tx        <= w_nextTx;
            r_idle      <= (w_nextState == IDLE) && !w_nextHoldValid;
        end
    end

`ifdef UART_SENDER_PARITY_EN
    // Parity of the byte, captured when it moves into the shift register.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_parity <= 1'b0;
        end else begin
            r_parity <= w_nextParity;
        end
    end
`endif

    assign TX_STATUS = !r_holdValid;
    assign TX_IDLE   = r_idle;
    assign UART_TX   = r_tx;

endmodule

// File: tb/tb_uart_sender.sv
// tb_uart_sender: self-checking bench for uart_sender.
//
// The model describes the line in terms of whole frames: each accepted byte
// gets an accept edge and a start edge, and the expected line level, holding
// state and idle flag at any edge follow from those numbers by arithmetic.
// A background receiver decodes the line at mid-bit so whole bytes can be
// compared against hand-written literals.

`timescale 1ns/1ps

module tb_uart_sender;

    localparam int CPB = 10;
`ifdef UART_SENDER_PARITY_EN
    localparam int NBITS = 11;
    localparam bit PAR   = 1'b1;
`else
    localparam int NBITS = 10;
    localparam bit PAR   = 1'b0;
`endif
    localparam int FRAME = NBITS * CPB;

    logic       sysclk  = 1'b0;
    logic       reset   = 1'b1;
    logic       TX_EN   = 1'b0;
    logic [7:0] TX_DATA = 8'h00;
    logic       TX_STATUS;
    logic       TX_IDLE;
    logic       UART_TX;

    int nCompared   = 0;
    int nMismatched = 0;
    int edgeNo      = 0;
    bit checking    = 1'b0;

    typedef struct {
        int         acc;
        int         s;
        logic [7:0] d;
    } frame_t;

    frame_t     frames[$];
    frame_t     newFrame;
    int         lastEnd;

    logic [7:0] rxQ[$];
    logic       rxParQ[$];
    logic [7:0] rxShift = 8'h00;
    int         rxCnt   = 0;
    int         rxK     = 0;
    bit         rxBusy  = 1'b0;

    uart_sender #(
        .CLK_FREQ (1_000_000),
        .BAUD     (100_000)
    ) dut (
        .sysclk    (sysclk),
        .reset     (reset),
        .TX_DATA   (TX_DATA),
        .TX_EN     (TX_EN),
        .TX_STATUS (TX_STATUS),
        .TX_IDLE   (TX_IDLE),
        .UART_TX   (UART_TX)
    );

    always #5 sysclk = ~sysclk;

    // Shared comparison helper; every check in the bench goes through here.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h (edge %0d)",
                     name, actual, expected, edgeNo);
        end
    endtask

    // Line level of bit k of a frame carrying byte d.
    function automatic logic lineBit(input logic [7:0] d, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
        if (PAR && k == 9) return ^d;
        return 1'b1;
    endfunction

    function automatic logic expLine(input int e);
        if (reset) return 1'b1;
        foreach (frames[i])
            if (e >= frames[i].s && e < frames[i].s + FRAME)
                return lineBit(frames[i].d, (e - frames[i].s) / CPB);
        return 1'b1;
    endfunction

    function automatic logic expStatus(input int e);
        if (reset) return 1'b1;
        foreach (frames[i])
            if (e >= frames[i].acc && e < frames[i].s) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic expIdle(input int e);
        if (reset) return 1'b1;
        foreach (frames[i])
            if (e >= frames[i].acc && e < frames[i].s + FRAME) return 1'b0;
        return 1'b1;
    endfunction

    // Model: a write is taken when the holding register was empty after the
    // previous edge; its frame starts on the next edge or when the line
    // frees up, whichever is later.
    always @(posedge sysclk) begin
        edgeNo = edgeNo + 1;
        if (reset) begin
            frames.delete();
        end else if (TX_EN && expStatus(edgeNo - 1)) begin
            lastEnd    = (frames.size() == 0) ? 0 : frames[$].s + FRAME;
            newFrame.acc = edgeNo;
            newFrame.s   = (edgeNo + 1 > lastEnd) ? edgeNo + 1 : lastEnd;
            newFrame.d   = TX_DATA;
            frames.push_back(newFrame);
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge sysclk) begin
        if (checking) begin
            checkOutput("UART_TX", {31'd0, UART_TX}, {31'd0, expLine(edgeNo)});
            checkOutput("TX_STATUS", {31'd0, TX_STATUS}, {31'd0, expStatus(edgeNo)});
            checkOutput("TX_IDLE", {31'd0, TX_IDLE}, {31'd0, expIdle(edgeNo)});
        end
    end

    // Mid-bit receiver; only frames with a valid stop bit are recorded.
    always @(negedge sysclk) begin
        if (reset) begin
            rxBusy = 1'b0;
        end else if (!rxBusy) begin
            if (UART_TX === 1'b0) begin
                rxBusy = 1'b1;
                rxCnt  = 0;
            end
        end else begin
            rxCnt = rxCnt + 1;
            if (rxCnt % CPB == CPB / 2) begin
                rxK = rxCnt / CPB;
                if (rxK >= 1 && rxK <= 8) begin
                    rxShift[rxK-1] = UART_TX;
                end else if (PAR && rxK == 9) begin
                    rxParQ.push_back(UART_TX);
                end else if (rxK == NBITS - 1) begin
                    if (UART_TX === 1'b1) rxQ.push_back(rxShift);
                    rxBusy = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic waitEdge(input int target);
        while (edgeNo < target) tick();
    endtask

    // One-cycle write strobe; called #1 after a rising edge and returns #1
    // after the edge that samples it.
    task automatic applyStimulus(input logic [7:0] d);
        TX_DATA = d;
        TX_EN   = 1'b1;
        @(posedge sysclk);
        #1;
        TX_EN   = 1'b0;
        TX_DATA = 8'($urandom);
    endtask

    task automatic waitStatus(input int limit);
        int n = 0;
        while (TX_STATUS !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
        checkOutput("statusWait", {31'd0, TX_STATUS}, 32'd1);
    endtask

    task automatic waitIdle(input int limit);
        int n = 0;
        while (TX_IDLE !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
        checkOutput("idleWait", {31'd0, TX_IDLE}, 32'd1);
    endtask

    task automatic checkRx(input string tag, input int count,
                           input logic [7:0] b0, input logic [7:0] b1);
        checkOutput({tag, "_rxCount"}, rxQ.size(), count);
        if (count > 0 && rxQ.size() > 0) checkOutput({tag, "_rx0"}, {24'd0, rxQ[0]}, {24'd0, b0});
        if (count > 1 && rxQ.size() > 1) checkOutput({tag, "_rx1"}, {24'd0, rxQ[1]}, {24'd0, b1});
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int s;
        int a;
        logic [NBITS-1:0] litA5;
`ifdef UART_SENDER_PARITY_EN
        litA5 = 11'b1_0_10100101_0;
`else
        litA5 = 10'b1_10100101_0;
`endif

        // Test 1: reset for 5 cycles, then a quiet line.
        $display("[TB] test 1: reset and idle line");
        reset = 1'b1;
        repeat (5) tick();
        checking = 1'b1;
        checkOutput("rst_tx", {31'd0, UART_TX}, 32'd1);
        checkOutput("rst_status", {31'd0, TX_STATUS}, 32'd1);
        checkOutput("rst_idle", {31'd0, TX_IDLE}, 32'd1);
        reset = 1'b0;
        repeat (200) tick();
        checkOutput("quiet_tx", {31'd0, UART_TX}, 32'd1);
        checkRx("quiet", 0, 8'h00, 8'h00);

        // Test 2: single byte 8'hA5, latency, bit values and frame length.
        $display("[TB] test 2: single frame 8'hA5");
        rxQ.delete();
        applyStimulus(8'hA5);
        a = edgeNo;
        checkOutput("A5_beforeStart", {31'd0, UART_TX}, 32'd1);
        tick();
        checkOutput("A5_startLow", {31'd0, UART_TX}, 32'd0);
        s = edgeNo;
        checkOutput("A5_startEdge", s - a, 32'd1);
        for (int k = 0; k < NBITS; k++) begin
            waitEdge(s + k * CPB + 5);
            checkOutput($sformatf("A5_bit%0d", k), {31'd0, UART_TX}, {31'd0, litA5[k]});
        end
        waitEdge(s + FRAME - 1);
        checkOutput("A5_idleBusy", {31'd0, TX_IDLE}, 32'd0);
        tick();
        checkOutput("A5_idleBack", {31'd0, TX_IDLE}, 32'd1);
        checkRx("A5", 1, 8'hA5, 8'h00);

        // Test 3: back-to-back frames with no idle gap.
        $display("[TB] test 3: back-to-back 8'h55, 8'h0F");
        repeat (7) tick();
        rxQ.delete();
        applyStimulus(8'h55);
        s = edgeNo + 1;
        waitStatus(20);
        applyStimulus(8'h0F);
        waitEdge(s + FRAME - 1);
        checkOutput("b2b_stop", {31'd0, UART_TX}, 32'd1);
        tick();
        checkOutput("b2b_noGap", {31'd0, UART_TX}, 32'd0);
        waitEdge(s + 2 * FRAME - 1);
        checkOutput("b2b_idleBusy", {31'd0, TX_IDLE}, 32'd0);
        tick();
        checkOutput("b2b_idleBack", {31'd0, TX_IDLE}, 32'd1);
        checkRx("b2b", 2, 8'h55, 8'h0F);

        // Test 4: a write while the holding register is full is dropped.
        $display("[TB] test 4: dropped write");
        repeat (3) tick();
        rxQ.delete();
        applyStimulus(8'h11);
        waitStatus(20);
        applyStimulus(8'h22);
        checkOutput("drop_status", {31'd0, TX_STATUS}, 32'd0);
        applyStimulus(8'h33);
        waitIdle(3 * FRAME);
        checkRx("drop", 2, 8'h11, 8'h22);

        // Test 5: reset mid-data abandons the frame and the held byte.
        $display("[TB] test 5: reset mid-frame");
        repeat (4) tick();
        rxQ.delete();
        applyStimulus(8'hC3);
        s = edgeNo + 1;
        waitStatus(20);
        applyStimulus(8'h99);
        waitEdge(s + 35);
        checkOutput("mid_lineLow", {31'd0, UART_TX}, 32'd0);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("mid_rstTx", {31'd0, UART_TX}, 32'd1);
        checkOutput("mid_rstStatus", {31'd0, TX_STATUS}, 32'd1);
        checkOutput("mid_rstIdle", {31'd0, TX_IDLE}, 32'd1);
        tick();
        tick();
        reset = 1'b0;
        repeat (3 * FRAME) tick();
        checkRx("abandon", 0, 8'h00, 8'h00);
        applyStimulus(8'h3C);
        waitIdle(2 * FRAME);
        checkRx("afterRst", 1, 8'h3C, 8'h00);

`ifdef UART_SENDER_PARITY_EN
        // Test 6: even parity bit and 11-bit frame length.
        $display("[TB] test 6: parity");
        repeat (5) tick();
        rxQ.delete();
        rxParQ.delete();
        applyStimulus(8'h07);
        s = edgeNo + 1;
        waitEdge(s + 9 * CPB + 5);
        checkOutput("par07_bit", {31'd0, UART_TX}, 32'd1);
        waitEdge(s + 109);
        checkOutput("par07_idleBusy", {31'd0, TX_IDLE}, 32'd0);
        tick();
        checkOutput("par07_frame110", {31'd0, TX_IDLE}, 32'd1);
        applyStimulus(8'h03);
        s = edgeNo + 1;
        waitEdge(s + 9 * CPB + 5);
        checkOutput("par03_bit", {31'd0, UART_TX}, 32'd0);
        waitIdle(2 * FRAME);
        checkRx("par", 2, 8'h07, 8'h03);
        checkOutput("par_rxCount", rxParQ.size(), 32'd2);
        if (rxParQ.size() > 1) begin
            checkOutput("par_rx07", {31'd0, rxParQ[0]}, 32'd1);
            checkOutput("par_rx03", {31'd0, rxParQ[1]}, 32'd0);
        end
`endif

        repeat (20) tick();
        checking = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
